fft_spectrum_framer: RTL and testbench



---
 rtl/fft_spectrum_framer.sv | 232 +++++++++++++++++++++++
 tb/tb_fft_spectrum_framer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_framer.sv
// Converts complex FFT bins to saturated magnitude-squared values, optionally
// averages 2^AVG_LOG2 frames, and streams the first NBINS bins of a frame as
// one byte packet: A5 5A seq bins... csum.
//
// state     | meaning
// WAIT_SYNC | idle; waiting for bin 0 of a frame
// CAPTURE   | writing bins 0..NBINS-1 into the accumulator
// DRAIN     | two cycles for the magnitude pipeline to land its last writes
// SEND_H0   | header byte 0xA5
// SEND_H1   | header byte 0x5A
// SEND_SEQ  | sequence byte
// SEND_BIN  | bin bytes, bin 0 first, MSB first
// SEND_CSUM | XOR of sequence and bin bytes
module fft_spectrum_framer #(
  parameter int IW       = 11,
  parameter int FFT_LEN  = 128,
  parameter int NBINS    = 64,
  parameter int OW       = 16,
  parameter int SHIFT    = 6,
  parameter int AVG_LOG2 = 0
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 in_ce,
  input  logic                 in_sync,
  input  logic signed [IW-1:0] in_re,
  input  logic signed [IW-1:0] in_im,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [7:0]           drop_count
);

  localparam int BW     = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int AW     = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int NBYTES = OW / 8;
  localparam int YW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int ACCW   = OW + AVG_LOG2;
  localparam int SW     = (2 * IW > OW) ? 2 * IW : OW + 1;
  localparam int CW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [BW:0]   NBINS_V   = (BW + 1)'(NBINS);
  localparam logic [BW:0]   LAST_BIN  = (BW + 1)'(NBINS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NBINS - 1);
  localparam logic [YW-1:0] LAST_BYTE = YW'(NBYTES - 1);
  localparam logic [CW-1:0] AVG_MAX   = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    WAIT_SYNC, CAPTURE, DRAIN, SEND_H0, SEND_H1, SEND_SEQ, SEND_BIN, SEND_CSUM
  } state_t;

  state_t state, state_d;

  logic [BW-1:0]         bin_cnt, cur_bin;
  logic                  in_range, cap_start, cap_wr, cap_last, restart, drop_evt;
  logic                  in_send, xfer, drain_done, last_byte, avg_last;
  logic [1:0]            drain_cnt;
  logic [CW-1:0]         avg_cnt;
  logic [7:0]            seq, csum, load_byte, bin_byte;
  logic [AW-1:0]         bin_idx;
  logic [YW-1:0]         byte_idx;

  logic signed [2*IW-1:0] re_sq_c, im_sq_c;
  logic                   p1_valid, p2_valid;
  logic [AW-1:0]          p1_addr, p2_addr;
  logic [2*IW-1:0]        p1_re_sq, p1_im_sq;
  logic [OW-1:0]          p2_mag, mag_c;
  logic [SW-1:0]          sum_w, shifted_w;

  logic [ACCW-1:0]        acc [NBINS];
  logic [ACCW-1:0]        rd_acc, rd_shift;
  logic [OW-1:0]          bin_word;

  assign cur_bin    = in_sync ? '0 : bin_cnt + 1'b1;
  assign in_range   = {1'b0, cur_bin} < NBINS_V;
  assign cap_start  = in_ce & in_sync & (state == WAIT_SYNC);
  assign cap_wr     = in_ce & in_range & (cap_start | (state == CAPTURE));
  assign cap_last   = cap_wr & ({1'b0, cur_bin} == LAST_BIN);
  assign restart    = in_ce & in_sync & (state == CAPTURE);
  assign in_send    = state inside {SEND_H0, SEND_H1, SEND_SEQ, SEND_BIN, SEND_CSUM};
  assign drop_evt   = in_ce & in_sync & ((state == CAPTURE) | in_send);
  assign xfer       = tx_valid & tx_ready;
  assign drain_done = (state == DRAIN) && (drain_cnt == 2'd0);
  assign last_byte  = (bin_idx == LAST_ADDR) && (byte_idx == LAST_BYTE);
  assign avg_last   = (avg_cnt == AVG_MAX);
  assign busy       = in_send;

  assign re_sq_c   = in_re * in_re;
  assign im_sq_c   = in_im * in_im;
  assign sum_w     = SW'(p1_re_sq) + SW'(p1_im_sq);
  assign shifted_w = sum_w >> SHIFT;
  assign mag_c     = (|shifted_w[SW-1:OW]) ? '1 : shifted_w[OW-1:0];

  assign rd_acc   = acc[bin_idx];
  assign rd_shift = rd_acc >> AVG_LOG2;
  assign bin_word = rd_shift[OW-1:0];

  // Select the current byte of the bin word, most significant byte first.
  always_comb begin
    bin_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_idx == YW'(k)) bin_byte = bin_word[OW-1-8*k -: 8];
    end
  end

  // State register.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) state <= WAIT_SYNC;
    else       state <= state_d;
  end

  // Next-state logic and the byte to present in each send state.
  always_comb begin
    state_d   = state;
    load_byte = 8'h00;
    case (state)
      WAIT_SYNC: if (cap_start) state_d = cap_last ? DRAIN : CAPTURE;
      CAPTURE:   if (cap_last) state_d = DRAIN;
      DRAIN:     if (drain_done) state_d = avg_last ? SEND_H0 : WAIT_SYNC;
      SEND_H0: begin
        load_byte = 8'hA5;
        if (xfer) state_d = SEND_H1;
      end
      SEND_H1: begin
        load_byte = 8'h5A;
        if (xfer) state_d = SEND_SEQ;
      end
      SEND_SEQ: begin
        load_byte = seq;
        if (xfer) state_d = SEND_BIN;
      end
      SEND_BIN: begin
        load_byte = bin_byte;
        if (xfer && last_byte) state_d = SEND_CSUM;
      end
      SEND_CSUM: begin
        load_byte = csum;
        if (xfer) state_d = WAIT_SYNC;
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  // Magnitude pipeline: squares, then shifted and saturated sum.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_addr  <= '0;
      p1_re_sq <= '0;
      p1_im_sq <= '0;
      p2_valid <= 1'b0;
      p2_addr  <= '0;
      p2_mag   <= '0;
    end else begin
      p1_valid <= cap_wr;
      p1_addr  <= cur_bin[AW-1:0];
      p1_re_sq <= re_sq_c;
      p1_im_sq <= im_sq_c;
      p2_valid <= p1_valid;
      p2_addr  <= p1_addr;
      p2_mag   <= mag_c;
    end
  end

  // Accumulator: the first frame of an average set overwrites, later ones add.
  always_ff @(posedge sys_clock) begin
    if (p2_valid) begin
      if (avg_cnt == '0) acc[p2_addr] <= ACCW'(p2_mag);
      else               acc[p2_addr] <= acc[p2_addr] + ACCW'(p2_mag);
    end
  end

  // Control counters, byte handshake, checksum and sequence.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      bin_cnt    <= '0;
      drain_cnt  <= '0;
      avg_cnt    <= '0;
      drop_count <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      bin_idx    <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      seq        <= '0;
    end else begin
      if (in_ce) bin_cnt <= cur_bin;

      if (cap_last)                                 drain_cnt <= 2'd1;
      else if (state == DRAIN && drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;

      if (restart)         avg_cnt <= '0;
      else if (drain_done) avg_cnt <= avg_last ? '0 : avg_cnt + 1'b1;

      if (drop_evt && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

      // Each byte is loaded while tx_valid is low, so valid drops for one
      // cycle between bytes while the accumulator read settles.
      if (in_send) begin
        if (!tx_valid) begin
          tx_valid <= 1'b1;
          tx_data  <= load_byte;
        end else if (tx_ready) begin
          tx_valid <= 1'b0;
        end
      end

      if (xfer) begin
        case (state)
          SEND_SEQ: begin
            csum     <= tx_data;
            bin_idx  <= '0;
            byte_idx <= '0;
          end
          SEND_BIN: begin
            csum <= csum ^ tx_data;
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              bin_idx  <= bin_idx + 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          SEND_CSUM: seq <= seq + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_spectrum_framer.sv
// Scoreboard bench for fft_spectrum_framer: expected packet bytes are queued
// when a frame is driven and popped as the DUT hands bytes over.
module tb_fft_spectrum_framer;

  logic               sys_clock = 1'b0;
  logic               reset;
  logic               in_ce_a, in_sync_a, in_ce_b, in_sync_b;
  logic signed [10:0] in_re, in_im;
  logic               tx_ready;
  logic [7:0]         tx_data_a, tx_data_b, drop_a, drop_b;
  logic               tx_valid_a, tx_valid_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_bytes_a = 0, n_bytes_b = 0, extra_a = 0, extra_b = 0;

  logic [7:0]         exp_qa[$];
  logic [7:0]         exp_qb[$];
  logic signed [10:0] fr_re [8];
  logic signed [10:0] fr_im [8];
  logic [15:0]        exp_word [4];
  logic [7:0]         t1_bytes [12];
  logic [7:0]         exp_seq;
  int                 base;

  always #5 sys_clock = ~sys_clock;

  fft_spectrum_framer #(.IW(11), .FFT_LEN(8), .NBINS(4), .OW(16), .SHIFT(0), .AVG_LOG2(0)) dut_a (
    .sys_clock(sys_clock), .reset(reset), .in_ce(in_ce_a), .in_sync(in_sync_a),
    .in_re(in_re), .in_im(in_im), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready), .busy(busy_a), .drop_count(drop_a));

  fft_spectrum_framer #(.IW(11), .FFT_LEN(8), .NBINS(4), .OW(16), .SHIFT(0), .AVG_LOG2(1)) dut_b (
    .sys_clock(sys_clock), .reset(reset), .in_ce(in_ce_b), .in_sync(in_sync_b),
    .in_re(in_re), .in_im(in_im), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready), .busy(busy_b), .drop_count(drop_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clock) begin
    if (!reset && tx_valid_a && tx_ready) begin
      n_bytes_a++;
      if (exp_qa.size() == 0) extra_a++;
      else check("byte_a", tx_data_a, exp_qa.pop_front());
    end
    if (!reset && tx_valid_b && tx_ready) begin
      n_bytes_b++;
      if (exp_qb.size() == 0) extra_b++;
      else check("byte_b", tx_data_b, exp_qb.pop_front());
    end
  end

  function automatic logic [15:0] mag_model(input logic signed [10:0] re, input logic signed [10:0] im);
    longint s;
    s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic set_bin(input int k, input int re, input int im);
    fr_re[k] = 11'(re);
    fr_im[k] = 11'(im);
  endtask

  task automatic words_from_frame();
    for (int k = 0; k < 4; k++) exp_word[k] = mag_model(fr_re[k], fr_im[k]);
  endtask

  task automatic push_pkt(input bit to_b, input logic [7:0] sq);
    logic [7:0] b[$];
    logic [7:0] cs;
    b.push_back(8'hA5);
    b.push_back(8'h5A);
    b.push_back(sq);
    cs = sq;
    for (int k = 0; k < 4; k++) begin
      b.push_back(exp_word[k][15:8]);
      b.push_back(exp_word[k][7:0]);
      cs = cs ^ exp_word[k][15:8] ^ exp_word[k][7:0];
    end
    b.push_back(cs);
    foreach (b[i]) begin
      if (to_b) exp_qb.push_back(b[i]);
      else      exp_qa.push_back(b[i]);
    end
  endtask

  task automatic drive_frame(input bit to_b, input int nb);
    for (int k = 0; k < nb; k++) begin
      @(posedge sys_clock); #1;
      if (to_b) begin in_ce_b = 1'b1; in_sync_b = (k == 0); end
      else      begin in_ce_a = 1'b1; in_sync_a = (k == 0); end
      in_re = fr_re[k];
      in_im = fr_im[k];
    end
    @(posedge sys_clock); #1;
    in_ce_a = 1'b0; in_sync_a = 1'b0; in_ce_b = 1'b0; in_sync_b = 1'b0;
  endtask

  task automatic wait_bytes_a(input int target);
    int t = 0;
    while (n_bytes_a < target && t < 300) begin
      @(negedge sys_clock);
      t++;
    end
    if (n_bytes_a < target) check("wait_bytes_timeout", n_bytes_a, target);
  endtask

  task automatic wait_drain(input bit to_b, input string tag);
    int t = 0;
    while (((to_b ? exp_qb.size() : exp_qa.size()) != 0) && t < 400) begin
      @(negedge sys_clock);
      t++;
    end
    check(tag, to_b ? exp_qb.size() : exp_qa.size(), 0);
    repeat (3) @(posedge sys_clock);
    #1;
  endtask

  initial begin
    int t;
    reset = 1'b1;
    tx_ready = 1'b1;
    in_ce_a = 0; in_sync_a = 0; in_ce_b = 0; in_sync_b = 0;
    in_re = '0; in_im = '0;
    exp_seq = 8'h00;
    t1_bytes = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h19, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h18};

    #12;
    check("rst_tx_valid", tx_valid_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_drop", drop_a, 0);
    check("rst_tx_valid_b", tx_valid_b, 0);
    @(posedge sys_clock); #1;
    reset = 1'b0;
    @(negedge sys_clock);
    check("idle_busy", busy_a, 0);

    // Test 1: packet contents, literal stream.
    set_bin(0, 3, 4); set_bin(1, -1024, -1024); set_bin(2, 0, 0); set_bin(3, 1, 0);
    set_bin(4, 5, 5); set_bin(5, 7, -2); set_bin(6, 100, 3); set_bin(7, -9, 0);
    foreach (t1_bytes[i]) exp_qa.push_back(t1_bytes[i]);
    drive_frame(0, 8);
    wait_bytes_a(3);
    check("t1_busy_sending", busy_a, 1);
    wait_drain(0, "t1_drain");
    check("t1_busy_after", busy_a, 0);
    check("t1_valid_after", tx_valid_a, 0);
    exp_seq = exp_seq + 8'd1;

    // Test 2: backpressure on the first bin byte.
    words_from_frame();
    push_pkt(0, exp_seq);
    base = n_bytes_a;
    drive_frame(0, 8);
    wait_bytes_a(base + 3);
    @(posedge sys_clock); #1;
    tx_ready = 1'b0;
    t = 0;
    while (!tx_valid_a && t < 20) begin @(negedge sys_clock); t++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clock);
      check("t2_hold_valid", tx_valid_a, 1);
      check("t2_hold_data", tx_data_a, 8'h00);
    end
    @(posedge sys_clock); #1;
    tx_ready = 1'b1;
    wait_drain(0, "t2_drain");
    exp_seq = exp_seq + 8'd1;

    // Test 3: a frame arriving during SEND_BIN is dropped.
    set_bin(0, 10, -20); set_bin(1, 300, 0); set_bin(2, -1, -1); set_bin(3, 0, 255);
    words_from_frame();
    push_pkt(0, exp_seq);
    base = n_bytes_a;
    drive_frame(0, 8);
    wait_bytes_a(base + 4);
    for (int k = 0; k < 8; k++) set_bin(k, 50, 50);
    drive_frame(0, 8);
    wait_drain(0, "t3_drain");
    check("t3_drop", drop_a, 1);
    exp_seq = exp_seq + 8'd1;
    set_bin(0, 2, 2); set_bin(1, -7, 6); set_bin(2, 12, 0); set_bin(3, 0, -1);
    words_from_frame();
    push_pkt(0, exp_seq);
    drive_frame(0, 8);
    wait_drain(0, "t3_next_drain");
    exp_seq = exp_seq + 8'd1;

    // Test 4: sync re-asserts after two bins.
    for (int k = 0; k < 8; k++) set_bin(k, 40, -40);
    drive_frame(0, 2);
    set_bin(0, 6, 8); set_bin(1, -3, 0); set_bin(2, 255, 1); set_bin(3, -100, -100);
    words_from_frame();
    push_pkt(0, exp_seq);
    drive_frame(0, 8);
    wait_drain(0, "t4_drain");
    check("t4_drop", drop_a, 2);
    exp_seq = exp_seq + 8'd1;

    // Test 5: two-frame average on the AVG_LOG2=1 instance.
    for (int k = 0; k < 8; k++) set_bin(k, 1, 3);
    drive_frame(1, 8);
    repeat (30) @(posedge sys_clock);
    #1;
    check("t5_no_pkt_after_a", n_bytes_b, 0);
    for (int k = 0; k < 4; k++) exp_word[k] = 16'h000B;
    push_pkt(1, 8'h00);
    for (int k = 0; k < 8; k++) set_bin(k, 2, 3);
    drive_frame(1, 8);
    wait_drain(1, "t5_drain");
    check("t5_pkt_len", n_bytes_b, 12);

    // Test 6: reset during SEND_BIN aborts immediately.
    set_bin(0, 9, 9); set_bin(1, 1, 1); set_bin(2, 4, 4); set_bin(3, 8, 0);
    words_from_frame();
    push_pkt(0, exp_seq);
    base = n_bytes_a;
    drive_frame(0, 8);
    wait_bytes_a(base + 4);
    @(posedge sys_clock); #1;
    tx_ready = 1'b0;
    t = 0;
    while (!tx_valid_a && t < 20) begin @(negedge sys_clock); t++; end
    @(posedge sys_clock); #3;
    check("t6_pre_valid", tx_valid_a, 1);
    reset = 1'b1;
    #1;
    check("t6_async_valid", tx_valid_a, 0);
    check("t6_async_busy", busy_a, 0);
    exp_qa.delete();
    @(posedge sys_clock); #1;
    reset = 1'b0;
    tx_ready = 1'b1;
    @(negedge sys_clock);
    check("t6_drop_cleared", drop_a, 0);
    check("t6_data_cleared", tx_data_a, 0);
    exp_seq = 8'h00;
    set_bin(0, 0, 1); set_bin(1, 2, 0); set_bin(2, -5, 5); set_bin(3, 11, -11);
    words_from_frame();
    push_pkt(0, exp_seq);
    drive_frame(0, 8);
    wait_drain(0, "t6_drain");

    check("extra_bytes_a", extra_a, 0);
    check("extra_bytes_b", extra_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
